// File: rtl/mp_add_pkg.sv
// Shared definitions for the word-serial multi-precision adder:
// the controller state encoding and the datapath word width.
package mp_add_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder32.sv
// Combinational 32-bit adder with carry-in/carry-out; the only arithmetic
// element on the operand path, reused once per word.
module adder32
  import mp_add_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WORD_W{1'b0}}, cin};

endmodule

// File: rtl/mp_add_seq.sv
// Word-serial multi-precision add/subtract: one 32-bit word per cycle through
// a single adder32, ready/valid handshake on both sides.
module mp_add_seq
  import mp_add_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  input  logic                    cin,
  input  logic                    sub,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                    cout,
  output logic                    ovf,
  output logic                    busy
);

  localparam int                IDX_W    = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WORDS - 1);

  state_t state_q, state_d;

  logic [WORDS-1:0][WORD_W-1:0] a_q;
  logic [WORDS-1:0][WORD_W-1:0] b_q;
  logic [WORDS-1:0][WORD_W-1:0] result_w;
  logic                         carry_q;
  logic [IDX_W-1:0]             idx_q;
  logic [WORD_W*WORDS-1:0]      sum_q;
  logic                         cout_q;
  logic                         ovf_q;

  logic                         take;
  logic                         run;
  logic                         last_word;
  logic [WORD_W-1:0]            add_sum;
  logic                         add_cout;

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case statement can leave a latch behind.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (idx_q == LAST_IDX) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign take      = in_valid && in_ready;
  assign run       = (state_q == ST_RUN);
  assign last_word = run && (idx_q == LAST_IDX);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  adder32 u_adder (
    .a    (a_q[idx_q]),
    .b    (b_q[idx_q]),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // NOTE: operand words are pure datapath, always loaded before use, so they
  // carry no reset; only control and the visible result are cleared.
  always_ff @(posedge clk) begin
    if (take) begin
      a_q <= a;
      b_q <= sub ? ~b : b;
    end else if (run) begin
      a_q[idx_q] <= add_sum;
    end
  end

  // Lower words of a_q already hold their sum words by the final RUN cycle.
  always_comb begin
    result_w            = a_q;
    result_w[WORDS-1]   = add_sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (take) begin
      carry_q <= sub ? 1'b1 : cin;
      idx_q   <= '0;
    end else if (run) begin
      carry_q <= add_cout;
      idx_q   <= idx_q + 1'b1;
      if (last_word) begin
        sum_q  <= result_w;
        cout_q <= add_cout;
        ovf_q  <= (a_q[WORDS-1][WORD_W-1] == b_q[WORDS-1][WORD_W-1]) &&
                  (add_sum[WORD_W-1] != a_q[WORDS-1][WORD_W-1]);
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS=4): directed vector table,
// reset-mid-run sequence, and random operations against a wide-arithmetic model.
module tb_mp_add_seq;

  localparam int WORDS = 4;
  localparam int W     = 32 * WORDS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int total = 0;
  int bad   = 0;

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] va;
    logic [W-1:0] vb;
    logic         vcin;
    logic         vsub;
    int           hold;
    logic [W-1:0] exp_sum;
    logic         exp_cout;
    logic         exp_ovf;
  } vec_t;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    logic [W-1:0] r;
    for (int i = 0; i < WORDS; i++) begin
      case ($urandom_range(0, 3))
        0:       r[i*32 +: 32] = 32'hFFFF_FFFF;
        1:       r[i*32 +: 32] = 32'h0;
        default: r[i*32 +: 32] = $urandom;
      endcase
    end
    return r;
  endfunction

  // Reference: exact integer arithmetic on wider values, then range tests.
  task automatic model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                       input logic s, output logic [W-1:0] r, output logic co,
                       output logic ov);
    logic [W:0]            u;
    logic signed [W+1:0]   sx, sy, e, smax, smin;
    sx   = $signed({{2{x[W-1]}}, x});
    sy   = $signed({{2{y[W-1]}}, y});
    smax = $signed({3'b000, {(W-1){1'b1}}});
    smin = $signed({3'b111, {(W-1){1'b0}}});
    if (s) begin
      e  = sx - sy;
      r  = x - y;
      co = (x >= y);
    end else begin
      u  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
      r  = u[W-1:0];
      co = u[W];
      e  = sx + sy + $signed({{(W+1){1'b0}}, c});
    end
    ov = (e > smax) || (e < smin);
  endtask

  task automatic run_op(input vec_t v, input string name);
    int  lat;
    int  waited;
    bit  stable;
    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check({name, "_in_ready"}, W'(in_ready), W'(1));
    a = v.va; b = v.vb; cin = v.vcin; sub = v.vsub;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      a = rand_word(); b = rand_word(); cin = $urandom; sub = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, W'(lat), W'(WORDS));
    check({name, "_sum"}, sum, v.exp_sum);
    check({name, "_cout"}, W'(cout), W'(v.exp_cout));
    check({name, "_ovf"}, W'(ovf), W'(v.exp_ovf));
    check({name, "_busy_in_ready"}, W'({busy, in_ready}), W'(2'b10));
    if (v.hold > 0) begin
      stable = 1'b1;
      for (int i = 0; i < v.hold; i++) begin
        @(posedge clk); #1;
        if (!out_valid || in_ready || sum !== v.exp_sum || cout !== v.exp_cout ||
            ovf !== v.exp_ovf) stable = 1'b0;
      end
      check({name, "_hold_stable"}, W'(stable), W'(1));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_after_take"}, W'({out_valid, in_ready, busy}), W'(3'b010));
    check({name, "_sum_held"}, sum, v.exp_sum);
  endtask

  vec_t vecs[7];

  initial begin
    vec_t rv;
    logic [W-1:0] ones;
    ones = '1;
    vecs[0] = '{va: W'(32'hFFFF_FFFF), vb: W'(1), vcin: 0, vsub: 0, hold: 10,
                exp_sum: W'(64'h1_0000_0000), exp_cout: 0, exp_ovf: 0};
    vecs[1] = '{va: ones, vb: '0, vcin: 1, vsub: 0, hold: 0,
                exp_sum: '0, exp_cout: 1, exp_ovf: 0};
    vecs[2] = '{va: W'(5), vb: W'(7), vcin: 1, vsub: 1, hold: 0,
                exp_sum: ones - W'(1), exp_cout: 0, exp_ovf: 0};
    vecs[3] = '{va: {1'b0, {(W-1){1'b1}}}, vb: W'(1), vcin: 0, vsub: 0, hold: 2,
                exp_sum: {1'b1, {(W-1){1'b0}}}, exp_cout: 0, exp_ovf: 1};
    vecs[4] = '{va: W'(32'h1234), vb: W'(32'h1234), vcin: 0, vsub: 1, hold: 0,
                exp_sum: '0, exp_cout: 1, exp_ovf: 0};
    vecs[5] = '{va: {1'b1, {(W-1){1'b0}}}, vb: W'(1), vcin: 0, vsub: 1, hold: 0,
                exp_sum: {1'b0, {(W-1){1'b1}}}, exp_cout: 1, exp_ovf: 1};
    vecs[6] = '{va: ones, vb: ones, vcin: 1, vsub: 0, hold: 0,
                exp_sum: ones, exp_cout: 1, exp_ovf: 0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("reset_ctrl", W'({in_ready, out_valid, busy}), W'(3'b100));
    check("reset_sum", sum, '0);
    check("reset_flags", W'({cout, ovf}), W'(2'b00));
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run_op(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an operation (at idx=2), then a clean re-run.
    @(posedge clk); #1;
    a = ones; b = W'(1); cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("midrun_busy", W'(busy), W'(1));
    rst_n = 1'b0;
    #1;
    check("midrun_reset_ctrl", W'({in_ready, out_valid, busy}), W'(3'b100));
    check("midrun_reset_sum", sum, '0);
    check("midrun_reset_flags", W'({cout, ovf}), W'(2'b00));
    #2;
    rst_n = 1'b1;
    run_op(vecs[0], "post_reset");

    for (int n = 0; n < 40; n++) begin
      rv.va   = rand_word();
      rv.vb   = rand_word();
      rv.vcin = $urandom;
      rv.vsub = $urandom;
      rv.hold = $urandom_range(0, 2);
      model(rv.va, rv.vb, rv.vcin, rv.vsub, rv.exp_sum, rv.exp_cout, rv.exp_ovf);
      run_op(rv, $sformatf("rand%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
